// File: rtl/xmtbuf_pkg.sv
// Serial-line constants and shifter state type, shared by the transmit and receive buffers.
package xmtbuf_pkg;

    localparam int SER_BITS_PER_FRAME = 10;
    localparam int SER_DATA_BITS      = 8;

    localparam logic SER_START_LEVEL = 1'b0;
    localparam logic SER_STOP_LEVEL  = 1'b1;
    localparam logic SER_IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_t;

    // Baud counter width; a single bit is the minimum even when clog2 would give zero.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/xmtbuf_xmt.sv
// Bit-serial 8N1 shifter: baud counter, frame state machine and data shift register.
module xmt
    import xmtbuf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [SER_DATA_BITS-1:0] parallel_in,
    output logic                     busy,
    output logic                     serial_out
);

    localparam int                 BW          = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [BW-1:0]      BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam int                 BIT_W       = $clog2(SER_DATA_BITS);
    localparam logic [BIT_W-1:0]   LAST_BIT    = BIT_W'(SER_DATA_BITS - 1);

    ser_state_t               r_state;
    logic [BW-1:0]            r_baud;
    logic [BIT_W-1:0]         r_bit;
    logic [SER_DATA_BITS-1:0] r_shift;
    logic                     r_serial;
    logic                     w_bit_end;

    assign w_bit_end  = (r_baud == '0);
    // Busy falls in the last stop-bit clock so a queued byte starts with no idle gap.
    assign busy       = (r_state != IDLE) && !((r_state == STOP) && w_bit_end);
    assign serial_out = r_serial;

    // NOTE: r_shift carries no reset; its content is meaningless until a load overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_serial <= SER_IDLE_LEVEL;
        end else if (load && !busy) begin
            r_state  <= START;
            r_baud   <= BAUD_RELOAD;
            r_bit    <= '0;
            r_shift  <= parallel_in;
            r_serial <= SER_START_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial <= SER_IDLE_LEVEL;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state  <= DATA;
                        r_baud   <= BAUD_RELOAD;
                        r_serial <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit == LAST_BIT) begin
                            r_state  <= STOP;
                            r_serial <= SER_STOP_LEVEL;
                        end else begin
                            r_bit    <= r_bit + BIT_W'(1);
                            r_shift  <= r_shift >> 1;
                            r_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_serial <= SER_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: rtl/xmtbuf.sv
// Transmit buffer: one-byte holding register with write/ready handshake in front of the 8N1 shifter.
module xmtbuf
    import xmtbuf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    output logic                     ready,
    input  logic [SER_DATA_BITS-1:0] data_in,
    output logic                     serial_out
);

    logic                     r_full;
    logic [SER_DATA_BITS-1:0] r_hold;
    logic                     w_busy;
    logic                     w_load;

    // Accept and transfer are exclusive: accept needs an empty register, transfer a full one.
    assign w_load = r_full && !w_busy;
    assign ready  = !r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (write && !r_full) begin
            r_full <= 1'b1;
            r_hold <= data_in;
        end else if (w_load) begin
            r_full <= 1'b0;
        end
    end

    xmt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_xmt (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .parallel_in(r_hold),
        .busy       (w_busy),
        .serial_out (serial_out)
    );

endmodule

// File: tb/tb_xmtbuf.sv
// Self-checking bench for xmtbuf: directed scenarios plus randomized writes against a frame-timing model.
module tb_xmtbuf;

    localparam int CPB   = 4;
    localparam int CPB2  = 2;
    localparam int FRAME = 10 * CPB;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       write   = 1'b0;
    logic       write2  = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data2   = 8'h00;
    logic       ready, serial_out, ready2, serial2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xmtbuf #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .ready     (ready),
        .data_in   (data_in),
        .serial_out(serial_out)
    );

    xmtbuf #(.CLKS_PER_BIT(CPB2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .write     (write2),
        .ready     (ready2),
        .data_in   (data2),
        .serial_out(serial2)
    );

    // Reference model: a frame is a byte plus the edge it left the holding register;
    // the line level is the frame bit selected by elapsed cycles / CPB.
    int         cyc         = 0;
    logic       m_active    = 1'b0;
    logic       m_hold_full = 1'b0;
    int         m_start     = 0;
    logic [7:0] m_frame     = 8'h00;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] m_accepted[$];
    logic       m_done, m_ready, m_serial;

    function automatic logic frame_level(input logic [7:0] d, input int bit_idx);
        if (bit_idx == 0) return 1'b0;
        if (bit_idx <= 8) return d[3'(bit_idx - 1)];
        return 1'b1;
    endfunction

    assign m_done   = m_active && (cyc - m_start == FRAME);
    assign m_ready  = !m_hold_full;
    assign m_serial = m_active ? frame_level(m_frame, (cyc - m_start - 1) / CPB) : 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_active    <= 1'b0;
            m_hold_full <= 1'b0;
        end else begin
            if (m_hold_full && (!m_active || m_done)) begin
                m_active    <= 1'b1;
                m_start     <= cyc;
                m_frame     <= m_hold;
                m_hold_full <= 1'b0;
            end else if (m_done) begin
                m_active <= 1'b0;
            end
            if (write && !m_hold_full) begin
                m_hold_full <= 1'b1;
                m_hold      <= data_in;
                m_accepted.push_back(data_in);
            end
        end
    end

    // Line decoder for the CPB=4 instance: samples each bit mid-cell.
    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    logic       rx_busy = 1'b0;
    int         rx_t0   = 0;
    logic [7:0] rx_sh   = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (serial_out === 1'b0) begin
                rx_busy <= 1'b1;
                rx_t0   <= cyc;
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                if (cyc - rx_t0 == k * CPB + CPB / 2) rx_sh[k-1] <= serial_out;
            end
            if (cyc - rx_t0 == 9 * CPB + CPB / 2) begin
                rx_bytes.push_back(rx_sh);
                rx_start.push_back(rx_t0);
                rx_busy <= 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        reset = 1'b1;
        tick(2);
        n_tests++;
        if (ready !== 1'b1 || serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b serial_out=%b, required 1/1", ready, serial_out);
        end
        reset = 1'b0;
        tick(2);
        write = 1'b1; data_in = 8'h5A;
        tick();
        write = 1'b0;
        tick(8);
        reset = 1'b1;
        tick();
        n_tests++;
        if (ready !== 1'b1 || serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe: ready=%b serial_out=%b, required 1/1", ready, serial_out);
        end
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (serial_out !== 1'b1 || ready !== 1'b1) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: %0d cycles off idle after reset, required 0", bad);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] f;
        f = {1'b1, 8'h55, 1'b0};
        write = 1'b1; data_in = 8'h55;
        tick();
        write = 1'b0;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_e0: ready=%b, required 0", ready);
        end
        tick();
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_e1: ready=%b, required 1", ready);
        end
        for (int i = 0; i < FRAME; i++) begin
            n_tests++;
            if (serial_out !== f[i / CPB]) begin
                n_fail++;
                $display("FAIL single_wave cycle %0d: serial_out=%b, required %b", i, serial_out, f[i / CPB]);
            end
            tick();
        end
        n_tests++;
        if (serial_out !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: serial_out=%b ready=%b, required 1/1", serial_out, ready);
        end
        tick(5);
    endtask

    task automatic test_back_to_back();
        int base;
        base = rx_bytes.size();
        write = 1'b1; data_in = 8'hA3;
        tick();
        write = 1'b0;
        tick(2);
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_before_e3: ready=%b, required 1", ready);
        end
        write = 1'b1; data_in = 8'h0F;
        tick();
        write = 1'b0;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: ready=%b, required 0", ready);
        end
        tick(90);
        n_tests++;
        if (rx_bytes.size() != base + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames, required 2", rx_bytes.size() - base);
        end else begin
            n_tests++;
            if (rx_bytes[base] !== 8'hA3 || rx_bytes[base+1] !== 8'h0F) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h, required a3 0f", rx_bytes[base], rx_bytes[base+1]);
            end
            n_tests++;
            if (rx_start[base+1] - rx_start[base] != FRAME) begin
                n_fail++;
                $display("FAIL b2b_gap: start spacing %0d, required %0d", rx_start[base+1] - rx_start[base], FRAME);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        base = rx_bytes.size();
        write = 1'b1; data_in = 8'h11;
        tick();
        write = 1'b0;
        tick(2);
        write = 1'b1; data_in = 8'h22;
        tick();
        write = 1'b0;
        tick();
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: ready=%b, required 0", ready);
        end
        write = 1'b1; data_in = 8'h33;
        tick();
        write = 1'b0;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_still_full: ready=%b, required 0", ready);
        end
        tick(100);
        n_tests++;
        if (rx_bytes.size() != base + 2) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d frames, required 2", rx_bytes.size() - base);
        end else begin
            n_tests++;
            if (rx_bytes[base] !== 8'h11 || rx_bytes[base+1] !== 8'h22) begin
                n_fail++;
                $display("FAIL ovf_data: got %h %h, required 11 22", rx_bytes[base], rx_bytes[base+1]);
            end
        end
    endtask

    task automatic test_cpb2();
        logic exp;
        write2 = 1'b1; data2 = 8'h00;
        tick();
        write2 = 1'b0;
        n_tests++;
        if (ready2 !== 1'b0) begin
            n_fail++;
            $display("FAIL cpb2_ready_e0: ready=%b, required 0", ready2);
        end
        tick();
        n_tests++;
        if (ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL cpb2_ready_e1: ready=%b, required 1", ready2);
        end
        for (int i = 0; i < 25; i++) begin
            exp = (i < 18) ? 1'b0 : 1'b1;
            n_tests++;
            if (serial2 !== exp) begin
                n_fail++;
                $display("FAIL cpb2_wave cycle %0d: serial_out=%b, required %b", i, serial2, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_holding_full();
        int base;
        int bad;
        bad = 0;
        write = 1'b1; data_in = 8'hC3;
        tick();
        write = 1'b0;
        tick();
        write = 1'b1; data_in = 8'h3C;
        tick();
        write = 1'b0;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rhf_holding: ready=%b, required 0", ready);
        end
        tick(5);
        reset = 1'b1;
        tick();
        n_tests++;
        if (ready !== 1'b1 || serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rhf_reset_edge: ready=%b serial_out=%b, required 1/1", ready, serial_out);
        end
        tick(2);
        reset = 1'b0;
        base = rx_bytes.size();
        for (int i = 0; i < 60; i++) begin
            if (serial_out !== 1'b1 || ready !== 1'b1) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0 || rx_bytes.size() != base) begin
            n_fail++;
            $display("FAIL rhf_discard: %0d busy cycles, %0d frames, required 0/0", bad, rx_bytes.size() - base);
        end
        write = 1'b1; data_in = 8'h7E;
        tick();
        write = 1'b0;
        tick(50);
        n_tests++;
        if (rx_bytes.size() != base + 1) begin
            n_fail++;
            $display("FAIL rhf_new_count: got %0d frames, required 1", rx_bytes.size() - base);
        end else begin
            n_tests++;
            if (rx_bytes[base] !== 8'h7E) begin
                n_fail++;
                $display("FAIL rhf_new_data: got %h, required 7e", rx_bytes[base]);
            end
        end
    endtask

    task automatic test_random();
        int base;
        base = rx_bytes.size();
        m_accepted.delete();
        for (int i = 0; i < 620; i++) begin
            write   = (i < 500) && ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom);
            tick();
            n_tests++;
            if (ready !== m_ready || serial_out !== m_serial) begin
                n_fail++;
                $display("FAIL random cycle %0d: ready=%b serial_out=%b, required %b/%b",
                         i, ready, serial_out, m_ready, m_serial);
            end
        end
        write = 1'b0;
        n_tests++;
        if (rx_bytes.size() - base != m_accepted.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d frames, required %0d", rx_bytes.size() - base, m_accepted.size());
        end else begin
            for (int j = 0; j < m_accepted.size(); j++) begin
                n_tests++;
                if (rx_bytes[base+j] !== m_accepted[j]) begin
                    n_fail++;
                    $display("FAIL random_data %0d: got %h, required %h", j, rx_bytes[base+j], m_accepted[j]);
                end
            end
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_cpb2();
        test_reset_holding_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
